// File: rtl/mem_responder.sv
// Word-organised RAM responder with a valid/ready request channel and LATENCY wait states.
// Optional MEM_RESP_ALIGN_CHECK_EN makes misaligned half/word accesses fault.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDXW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;

  logic [31:0] ram [DEPTH_WORDS];

  logic            accept;
  logic            in_err;
  logic            commit;
  logic            cur_write;
  logic            cur_err;
  logic [31:0]     cur_addr;
  logic [31:0]     cur_wdata;
  logic [1:0]      cur_size;
  logic [IDXW-1:0] cur_idx;
  logic [3:0]      be;
  logic [31:0]     wword;

  // With LATENCY==0 the commit edge is the acceptance edge, so the live
  // request fields are used while IDLE and the latched copies afterwards.
  always_comb begin
    accept = (state_q == IDLE) && req_valid && req_ready;
    in_err = (req_addr[31:2] >= 30'(DEPTH_WORDS));
`ifdef MEM_RESP_ALIGN_CHECK_EN
    if ((req_size == 2'd1) && req_addr[0])
      in_err = 1'b1;
    if (req_size[1] && (req_addr[1:0] != 2'd0))
      in_err = 1'b1;
`endif
    if (state_q == IDLE) begin
      cur_write = req_write;
      cur_err   = in_err;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_size  = req_size;
    end else begin
      cur_write = write_q;
      cur_err   = err_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_size  = size_q;
    end
    commit  = ((LATENCY == 0) && accept) || ((state_q == WAIT) && (cnt_q == 4'd0));
    cur_idx = cur_addr[IDXW+1:2];
    unique case (cur_size)
      2'd0: begin
        be    = 4'b0001 << cur_addr[1:0];
        wword = {4{cur_wdata[7:0]}};
      end
      2'd1: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{cur_wdata[15:0]}};
      end
      default: begin
        be    = '1;
        wword = cur_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && commit && cur_write && !cur_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i])
          ram[cur_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            write_q   <= req_write;
            err_q     <= in_err;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            size_q    <= req_size;
            cnt_q     <= LAT_LOAD;
            req_ready <= 1'b0;
            state_q   <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
          else
            state_q <= RESP;
        end
        RESP: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= cur_err;
        resp_rdata <= (cur_write || cur_err) ? '0 : ram[cur_idx];
      end
    end
  end

endmodule
